// File: rtl/img_preproc_pkg.sv
// Shared types and constants for the image pre-processing stream front-end.
package img_preproc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } preproc_state_t;

   localparam int unsigned MODE_XY   = 0;
   localparam int unsigned MODE_RGB  = 1;
   localparam int unsigned MODE_GRAY = 2;

   localparam int unsigned GRAY_R = 77;
   localparam int unsigned GRAY_G = 150;
   localparam int unsigned GRAY_B = 29;

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned FRAME_W = 16;
   localparam int unsigned OUT_W   = 32;

   // Coefficients sum to 256, so the 16-bit accumulator cannot overflow.
   function automatic logic [7:0] gray_of(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
      logic [15:0] acc;
      acc = 16'(GRAY_R) * 16'(r) + 16'(GRAY_G) * 16'(g) + 16'(GRAY_B) * 16'(b);
      return acc[15:8];
   endfunction

endpackage

// File: rtl/img_pix_fmt.sv
// Pixel formatter plus single-entry output register with stall backpressure.
module img_pix_fmt
   import img_preproc_pkg::*;
#(
   parameter int unsigned OUT_MODE = MODE_XY
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pix_valid,
   input  logic [15:0]      pix_x,
   input  logic [15:0]      pix_y,
   input  logic [7:0]       pix_r,
   input  logic [7:0]       pix_g,
   input  logic [7:0]       pix_b,
   output logic             pix_accept,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             downstream_stall
);

   logic [OUT_W-1:0] fmt_word;

   always_comb begin
      fmt_word = {pix_x, pix_y};
      case (OUT_MODE)
         MODE_RGB:  fmt_word = {8'h00, pix_r, pix_g, pix_b};
         MODE_GRAY: fmt_word = {pix_x[11:0], pix_y[11:0], gray_of(pix_r, pix_g, pix_b)};
         default:   fmt_word = {pix_x, pix_y};
      endcase
   end

   assign pix_accept = !out_valid || !downstream_stall;

   // A new pixel may replace the held word in the same cycle it is consumed.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (pix_valid && pix_accept) begin
         out_valid <= 1'b1;
         out_data  <= fmt_word;
      end else if (!downstream_stall) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/img_preproc_stream.sv
// Length-prefixed byte stream to JPEG decoder adapter with pixel output formatting.
// Optional stall-timeout abort is compiled in with IMG_PREPROC_TIMEOUT_EN.
module img_preproc_stream
   import img_preproc_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned OUT_MODE       = MODE_XY,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_valid,
   output logic                 upstream_stall,
   output logic [OUT_W-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 downstream_stall,
   output logic                 dec_rst,
   output logic                 dec_valid,
   output logic [DATA_W-1:0]    dec_data,
   output logic [DATA_W/8-1:0]  dec_strb,
   output logic                 dec_last,
   input  logic                 dec_accept,
   input  logic                 dec_idle,
   input  logic                 pix_valid,
   input  logic [15:0]          pix_x,
   input  logic [15:0]          pix_y,
   input  logic [7:0]           pix_r,
   input  logic [7:0]           pix_g,
   input  logic [7:0]           pix_b,
   output logic                 pix_accept,
   output logic                 frame_error,
   output logic [FRAME_W-1:0]   frame_count
);

   localparam int unsigned BPW = DATA_W / 8;

   if (DATA_W < 16 || (DATA_W % 8) != 0) begin : g_bad_data_w
      $error("img_preproc_stream: DATA_W must be a multiple of 8 and at least 16");
   end
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("img_preproc_stream: TIMEOUT_CYCLES must be nonzero");
   end

   preproc_state_t   state, state_nxt;
   logic [CNT_W-1:0] byte_count;
   logic             hdr_zero;
   logic             last_word;
   logic             xfer;
   logic             drain_done;
   logic             abort;

   assign hdr_zero   = (in_data == '0);
   assign last_word  = (byte_count <= CNT_W'(BPW));
   assign xfer       = in_valid && !upstream_stall;
   assign drain_done = (state == ST_DRAIN) && dec_idle && !out_valid;
   assign dec_data   = in_data;

`ifdef IMG_PREPROC_TIMEOUT_EN
   logic [CNT_W-1:0] idle_cnt;

   // Abort fires on the stall cycle that would bring the count to the limit.
   assign abort = (state == ST_STREAM) && !(in_valid && dec_accept)
                  && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset || state != ST_STREAM || abort || xfer) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end
`else
   assign abort = 1'b0;
`endif

   assign frame_error = abort && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (in_valid && !hdr_zero) state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (abort)                  state_nxt = ST_IDLE;
            else if (xfer && last_word) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      upstream_stall = 1'b0;
      dec_valid      = 1'b0;
      dec_last       = 1'b0;
      dec_strb       = '0;
      dec_rst        = reset || abort;
      case (state)
         ST_IDLE: begin
            if (in_valid && hdr_zero) dec_rst = 1'b1;
         end
         ST_STREAM: begin
            upstream_stall = !dec_accept || abort;
            dec_valid      = in_valid;
            dec_last       = in_valid && last_word;
            for (int unsigned i = 0; i < BPW; i++) begin
               dec_strb[i] = (i < byte_count);
            end
         end
         ST_DRAIN: begin
            upstream_stall = 1'b1;
         end
         default: ;
      endcase
   end

   // Byte budget and frame counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         byte_count  <= '0;
         frame_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && !hdr_zero) byte_count <= CNT_W'(in_data);
            end
            ST_STREAM: begin
               if (abort)          byte_count <= '0;
               else if (xfer)      byte_count <= last_word ? '0 : byte_count - CNT_W'(BPW);
            end
            ST_DRAIN: begin
               if (drain_done) frame_count <= frame_count + FRAME_W'(1);
            end
            default: ;
         endcase
      end
   end

   img_pix_fmt #(
      .OUT_MODE (OUT_MODE)
   ) u_pix_fmt (
      .clock            (clock),
      .reset            (reset),
      .pix_valid        (pix_valid),
      .pix_x            (pix_x),
      .pix_y            (pix_y),
      .pix_r            (pix_r),
      .pix_g            (pix_g),
      .pix_b            (pix_b),
      .pix_accept       (pix_accept),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .downstream_stall (downstream_stall)
   );

endmodule

// File: tb/tb_img_preproc_stream.sv
// Directed self-checking bench for img_preproc_stream (DATA_W=32, gray output mode).
module tb_img_preproc_stream;

   logic        clock;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        upstream_stall;
   logic [31:0] out_data;
   logic        out_valid;
   logic        downstream_stall;
   logic        dec_rst;
   logic        dec_valid;
   logic [31:0] dec_data;
   logic [3:0]  dec_strb;
   logic        dec_last;
   logic        dec_accept;
   logic        dec_idle;
   logic        pix_valid;
   logic [15:0] pix_x, pix_y;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        pix_accept;
   logic        frame_error;
   logic [15:0] frame_count;

   int total = 0;
   int bad   = 0;

   img_preproc_stream #(
      .DATA_W         (32),
      .OUT_MODE       (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .upstream_stall   (upstream_stall),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .downstream_stall (downstream_stall),
      .dec_rst          (dec_rst),
      .dec_valid        (dec_valid),
      .dec_data         (dec_data),
      .dec_strb         (dec_strb),
      .dec_last         (dec_last),
      .dec_accept       (dec_accept),
      .dec_idle         (dec_idle),
      .pix_valid        (pix_valid),
      .pix_x            (pix_x),
      .pix_y            (pix_y),
      .pix_r            (pix_r),
      .pix_g            (pix_g),
      .pix_b            (pix_b),
      .pix_accept       (pix_accept),
      .frame_error      (frame_error),
      .frame_count      (frame_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic set_pix(input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      pix_x = x; pix_y = y; pix_r = r; pix_g = g; pix_b = b;
   endtask

   logic [3:0] exp_strb [3] = '{4'hF, 4'hF, 4'h3};
   logic       exp_last [3] = '{1'b0, 1'b0, 1'b1};

   initial begin
      reset = 1'b1; in_data = '0; in_valid = 1'b0; downstream_stall = 1'b0;
      dec_accept = 1'b1; dec_idle = 1'b0; pix_valid = 1'b0;
      set_pix(16'd0, 16'd0, 8'd0, 8'd0, 8'd0);

      // Reset values
      @(negedge clock); #1;
      chk("rst_dec_rst",     32'(dec_rst), 32'd1);
      chk("rst_out_valid",   32'(out_valid), 32'd0);
      chk("rst_out_data",    out_data, 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_frame_error", 32'(frame_error), 32'd0);
      cyc();
      reset = 1'b0; #1;
      chk("idle_stall",   32'(upstream_stall), 32'd0);
      chk("idle_dec_rst", 32'(dec_rst), 32'd0);

      // Frame of 10 bytes: three payload words
      in_data = 32'd10; in_valid = 1'b1; #1;
      chk("hdr_dec_valid", 32'(dec_valid), 32'd0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hA000_0000 + 32'(i); #1;
         chk("f10_dec_valid", 32'(dec_valid), 32'd1);
         chk("f10_dec_data",  dec_data, 32'hA000_0000 + 32'(i));
         chk("f10_strb",      32'(dec_strb), 32'(exp_strb[i]));
         chk("f10_last",      32'(dec_last), 32'(exp_last[i]));
         chk("f10_stall",     32'(upstream_stall), 32'd0);
         cyc();
      end
      in_valid = 1'b0; #1;
      chk("drain_stall",     32'(upstream_stall), 32'd1);
      chk("drain_dec_valid", 32'(dec_valid), 32'd0);
      chk("drain_fc",        32'(frame_count), 32'd0);
      cyc(); #1;
      chk("drain_hold_stall", 32'(upstream_stall), 32'd1);
      dec_idle = 1'b1;
      cyc(); #1;
      chk("f10_fc",         32'(frame_count), 32'd1);
      chk("f10_idle_stall", 32'(upstream_stall), 32'd0);
      chk("f10_frame_err",  32'(frame_error), 32'd0);

      // Frame of 8 bytes with dec_accept 1,0,1
      in_data = 32'd8; in_valid = 1'b1; cyc();
      in_data = 32'hB000_0000; dec_accept = 1'b1; #1;
      chk("f8_w0_stall", 32'(upstream_stall), 32'd0);
      chk("f8_w0_strb",  32'(dec_strb), 32'hF);
      chk("f8_w0_last",  32'(dec_last), 32'd0);
      cyc();
      in_data = 32'hB000_0001; dec_accept = 1'b0; #1;
      chk("f8_hold_stall", 32'(upstream_stall), 32'd1);
      chk("f8_hold_valid", 32'(dec_valid), 32'd1);
      chk("f8_hold_last",  32'(dec_last), 32'd1);
      cyc();
      dec_accept = 1'b1; #1;
      chk("f8_w1_stall", 32'(upstream_stall), 32'd0);
      chk("f8_w1_strb",  32'(dec_strb), 32'hF);
      chk("f8_w1_last",  32'(dec_last), 32'd1);
      cyc();
      in_valid = 1'b0; #1;
      chk("f8_drain_stall", 32'(upstream_stall), 32'd1);
      cyc(); #1;
      chk("f8_fc", 32'(frame_count), 32'd2);
      chk("f8_idle_stall", 32'(upstream_stall), 32'd0);

      // Zero word in IDLE pulses dec_rst for one cycle
      in_data = 32'd0; in_valid = 1'b1; #1;
      chk("zero_dec_rst", 32'(dec_rst), 32'd1);
      chk("zero_stall",   32'(upstream_stall), 32'd0);
      cyc();
      in_valid = 1'b0; #1;
      chk("zero_dec_rst_end", 32'(dec_rst), 32'd0);
      chk("zero_fc",          32'(frame_count), 32'd2);

      // Frame of 1 byte; header also confirms the block stayed in IDLE
      in_data = 32'd1; in_valid = 1'b1; #1;
      chk("f1_hdr_dec_valid", 32'(dec_valid), 32'd0);
      cyc();
      in_data = 32'hC000_0000; #1;
      chk("f1_strb", 32'(dec_strb), 32'h1);
      chk("f1_last", 32'(dec_last), 32'd1);
      cyc();
      in_valid = 1'b0; cyc(); #1;
      chk("f1_fc", 32'(frame_count), 32'd3);

      // Gray-mode pixels
      set_pix(16'd3, 16'd5, 8'd255, 8'd255, 8'd255); pix_valid = 1'b1; #1;
      chk("pix_accept_empty", 32'(pix_accept), 32'd1);
      cyc();
      set_pix(16'd7, 16'd9, 8'd100, 8'd0, 8'd0); #1;
      chk("pix0_valid", 32'(out_valid), 32'd1);
      chk("pix0_data",  out_data, 32'h0030_05FF);
      cyc(); #1;
      chk("pix1_data", out_data, 32'h0070_091E);

      // Downstream stall holds the current word
      set_pix(16'd1, 16'd2, 8'd0, 8'd100, 8'd0); downstream_stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("stall_accept", 32'(pix_accept), 32'd0);
         chk("stall_data",   out_data, 32'h0070_091E);
         chk("stall_valid",  32'(out_valid), 32'd1);
         cyc();
      end
      downstream_stall = 1'b0; #1;
      chk("unstall_accept", 32'(pix_accept), 32'd1);
      cyc();
      pix_valid = 1'b0; #1;
      chk("pix2_data", out_data, 32'h0010_023A);
      cyc(); #1;
      chk("pix_drained", 32'(out_valid), 32'd0);

      // Reset mid-frame with a pixel in flight
      in_data = 32'd20; in_valid = 1'b1; cyc();
      in_data = 32'hD000_0000; set_pix(16'd4, 16'd4, 8'd10, 8'd10, 8'd10); pix_valid = 1'b1;
      cyc(); #1;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      reset = 1'b1; in_valid = 1'b0; #1;
      chk("mid_rst_dec_rst", 32'(dec_rst), 32'd1);
      cyc();
      reset = 1'b0; pix_valid = 1'b0; #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_out_data",  out_data, 32'd0);
      chk("post_rst_fc",        32'(frame_count), 32'd0);
      chk("post_rst_stall",     32'(upstream_stall), 32'd0);
      in_data = 32'd4; in_valid = 1'b1; #1;
      chk("post_rst_hdr_valid", 32'(dec_valid), 32'd0);
      cyc();
      in_data = 32'hE000_0000; #1;
      chk("post_rst_strb", 32'(dec_strb), 32'hF);
      chk("post_rst_last", 32'(dec_last), 32'd1);
      cyc();
      in_valid = 1'b0; cyc(); #1;
      chk("post_rst_fc1", 32'(frame_count), 32'd1);

`ifdef IMG_PREPROC_TIMEOUT_EN
      // Stall timeout: abort on the 16th idle cycle in STREAM
      in_data = 32'd12; in_valid = 1'b1; cyc();
      in_valid = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         #1;
         chk("tmo_frame_error", 32'(frame_error), (k == 16) ? 32'd1 : 32'd0);
         chk("tmo_dec_rst",     32'(dec_rst),     (k == 16) ? 32'd1 : 32'd0);
         cyc();
      end
      #1;
      chk("tmo_err_end",   32'(frame_error), 32'd0);
      chk("tmo_idle_stall", 32'(upstream_stall), 32'd0);
      chk("tmo_fc",        32'(frame_count), 32'd1);
      in_data = 32'd4; in_valid = 1'b1; #1;
      chk("tmo_hdr_valid", 32'(dec_valid), 32'd0);
      cyc();
      in_data = 32'hF000_0000; #1;
      chk("tmo_new_strb", 32'(dec_strb), 32'hF);
      chk("tmo_new_last", 32'(dec_last), 32'd1);
      cyc();
      in_valid = 1'b0; cyc(); #1;
      chk("tmo_new_fc", 32'(frame_count), 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/img_preproc_stream.md
# img_preproc_stream

Parametrised successor to the DE1SOC JPEG front-end adapter. It accepts a length-prefixed byte stream, drives a JPEG decoder core through a proper valid/accept handshake, and formats decoded pixels into 32-bit output words in one of three modes. It sits between the host FIFO and the downstream pixel consumer. The decoder core is instantiated outside this block and connects through the `dec_*` and `pix_*` ports.

## Interface
- DATA_W, 32: input word width; a multiple of 8, at least 16. BPW = DATA_W/8 bytes per word.
- OUT_MODE, 0: output format. 0 = {x,y}; 1 = {8'h00,r,g,b}; 2 = {x[11:0],y[11:0],gray}.
- TIMEOUT_CYCLES, 1024: stall-timeout limit. Used only when the timeout feature is compiled in.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_data  in  DATA_W  header or payload word
- in_valid  in  1  in_data valid
- upstream_stall  out  1  word not taken this cycle
- out_data  out  32  formatted pixel
- out_valid  out  1  out_data valid
- downstream_stall  in  1  consumer not ready
- dec_rst  out  1  decoder reset
- dec_valid  out  1  payload word valid to decoder
- dec_data  out  DATA_W  payload word (equals in_data)
- dec_strb  out  BPW  byte-valid mask
- dec_last  out  1  final payload word
- dec_accept  in  1  decoder takes word
- dec_idle  in  1  decoder idle
- pix_valid  in  1  decoder pixel valid
- pix_x, pix_y  in  16 each  pixel coordinates
- pix_r, pix_g, pix_b  in  8 each  pixel colour
- pix_accept  out  1  pixel taken
- frame_error  out  1  one-cycle pulse on timeout abort
- frame_count  out  16  completed frames, wraps

## Operation
- Word transfer: a word moves upstream when `in_valid && !upstream_stall`.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - `upstream_stall`=0.
  - A nonzero word is latched into the 32-bit `byte_count` (zero-extended or truncated to 32 bits), then go to STREAM.
  - A zero word causes a one-cycle `dec_rst` pulse; stay in IDLE.
- STREAM:
  - `dec_valid`=in_valid, `upstream_stall`=!dec_accept.
  - On each transfer: `byte_count` -= BPW, saturating at 0.
  - `dec_last` = in_valid && byte_count<=BPW. When the last word transfers, go to DRAIN.
- Strobe: `dec_strb` is all ones when byte_count>=BPW, otherwise (1<<byte_count)-1 (low bytes valid).
- DRAIN:
  - `upstream_stall`=1.
  - When dec_idle && !out_valid: increment frame_count and go to IDLE.
- `dec_rst` = reset | abort pulse.
- Pixel formatter (mode 2): gray = (77·r + 150·g + 29·b) >> 8, computed in 16 bits; the result is never above 255.
- Output stage: a single register.
  - pix_accept = !out_valid || !downstream_stall.
  - On `pix_valid && pix_accept`, load the formatted word and set out_valid.
  - Clear out_valid when it is consumed with no new pixel arriving.
- Pixels are accepted in every state; the output stage is independent of the FSM.

## Timing
- Reset values: state IDLE, byte_count 0, out_valid 0, out_data 0, frame_count 0, frame_error 0, dec_rst 1 (during reset).
- Reset mid-frame: return to IDLE immediately. The output register is cleared and in-flight pixels are dropped.
- Header latch: 1 cycle. The first payload word can transfer in the cycle after the header.
- Pixel latency: pix_valid to out_valid is 1 cycle. Throughput is one pixel per cycle while downstream_stall=0.
- Simultaneous events in STREAM: if dec_accept=0 and the timeout expires in the same cycle, the abort wins and no word is transferred.
- A frame of BPW·k bytes ends on exactly k payload transfers. A frame of 1 byte ends on one transfer with strb=0…01.
- dec_* outputs are combinational from state and in_valid. pix_accept is combinational from out_valid and downstream_stall.

## Configuration
- Macro: `IMG_PREPROC_TIMEOUT_EN`.
- Defined:
  - In STREAM, a 32-bit counter increments on every cycle with no transfer and clears on every transfer.
  - At TIMEOUT_CYCLES the block pulses dec_rst and frame_error for one cycle, clears byte_count, and goes to IDLE. frame_count does not increment.
- Undefined: there is no counter, frame_error is tied to 0, and STREAM waits indefinitely.

## Structure
- Package `img_preproc_pkg` holds:
  - the state enum `preproc_state_t`;
  - the OUT_MODE constants `MODE_XY`, `MODE_RGB`, `MODE_GRAY`;
  - the gray coefficients `GRAY_R`, `GRAY_G`, `GRAY_B` (77/150/29).
- Sub-module `img_pix_fmt` contains the formatter and the output register (pix_* in, out_* out, downstream_stall, OUT_MODE).

## Test plan
- DATA_W=32, header 10, three payload words, dec_accept=1 → strb 1111, 1111, 0011; dec_last only on the third word; frame_count 0→1 once dec_idle=1.
- Header 8, dec_accept toggling 1,0,1 → exactly two transfers; upstream_stall=1 only in the dec_accept=0 cycle; byte_count 8→4→0.
- Zero word in IDLE → dec_rst high for exactly 1 cycle; state stays IDLE; frame_count unchanged.
- OUT_MODE=2, pixel r=255, g=255, b=255, x=3, y=5 → out_data = {12'd3, 12'd5, 8'd255} one cycle later. Then r=100, g=0, b=0 → gray 30.
- downstream_stall=1 for 4 cycles with pix_valid held → pix_accept=0 and out_data stable; the first pixel is not overwritten.
- With `IMG_PREPROC_TIMEOUT_EN`, TIMEOUT_CYCLES=16, header 12, then in_valid=0 → frame_error and dec_rst pulse on stall cycle 16; state IDLE; the next nonzero word is taken as a new header.
